p_beid_interconnect_f0_ahb_mtx_decoder: RTL and testbench

//   Address decoder and response multiplexer for one AHB matrix output port.

---
 rtl/p_beid_interconnect_f0_ahb_mtx_decoder.sv | 89 ++++++++
 tb/tb_p_beid_interconnect_f0_ahb_mtx_decoder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/p_beid_interconnect_f0_ahb_mtx_decoder.sv
// AHB matrix output-port address decoder plus data-phase response mux.
// Combinational address-phase selects; the registered data-phase select steers HREADYOUT/HRESP/HRDATA with no added latency.
module p_beid_interconnect_f0_ahb_mtx_decoder #(
  parameter int                     NSLV   = 4,
  parameter int                     ADDR_W = 32,
  parameter int                     DATA_W = 32,
  parameter logic [NSLV*ADDR_W-1:0] BASE   = {NSLV{32'h0}},
  parameter logic [NSLV*ADDR_W-1:0] MASK   = {NSLV{32'hF000_0000}}
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     HSEL,
  input  logic [ADDR_W-1:0]        HADDR,
  input  logic [1:0]               HTRANS,
  input  logic                     HREADY,
  output logic [NSLV-1:0]          HSELS,
  output logic                     HSELDEF,
  input  logic [NSLV-1:0]          HREADYOUTS,
  input  logic [2*NSLV-1:0]        HRESPS,
  input  logic [NSLV*DATA_W-1:0]   HRDATAS,
  input  logic                     HREADYOUTDEF,
  input  logic [1:0]               HRESPDEF,
  output logic                     HREADYOUT,
  output logic [1:0]               HRESP,
  output logic [DATA_W-1:0]        HRDATA
);

  logic [NSLV-1:0]   hit;
  logic [NSLV-1:0]   sel_pri;
  logic              lower_hit;
  logic [NSLV:0]     dsel_d;
  logic [NSLV:0]     dsel_q;
  logic              rdy_or;
  logic [1:0]        resp_or;
  logic [DATA_W-1:0] data_or;

  // Slaves qualify transfers with HTRANS themselves; the decoder ignores it.
  logic unused_htrans;
  assign unused_htrans = ^HTRANS;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NSLV; i++) begin
      hit[i] = ((HADDR & MASK[i*ADDR_W +: ADDR_W]) == (BASE[i*ADDR_W +: ADDR_W] & MASK[i*ADDR_W +: ADDR_W]));
    end
  end

  // Overlapping regions resolve to the lowest index.
  always_comb begin
    sel_pri   = '0;
    lower_hit = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      sel_pri[i] = hit[i] & ~lower_hit;
      lower_hit  = lower_hit | hit[i];
    end
  end

  assign HSELS   = {NSLV{HSEL}} & sel_pri;
  assign HSELDEF = HSEL & ~(|hit);

  assign dsel_d = HREADY ? {HSELDEF, HSELS} : dsel_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_q <= '0;
    end else begin
      dsel_q <= dsel_d;
    end
  end

  // AND-OR mux so an unknown on a deselected slave cannot leak through.
  always_comb begin
    rdy_or  = 1'b0;
    resp_or = '0;
    data_or = '0;
    for (int i = 0; i < NSLV; i++) begin
      rdy_or  = rdy_or  | (dsel_q[i] & HREADYOUTS[i]);
      resp_or = resp_or | ({2{dsel_q[i]}} & HRESPS[2*i +: 2]);
      data_or = data_or | ({DATA_W{dsel_q[i]}} & HRDATAS[i*DATA_W +: DATA_W]);
    end
    rdy_or  = rdy_or  | (dsel_q[NSLV] & HREADYOUTDEF);
    resp_or = resp_or | ({2{dsel_q[NSLV]}} & HRESPDEF);
  end

  assign HREADYOUT = ~(|dsel_q) | rdy_or;
  assign HRESP     = resp_or;
  assign HRDATA    = data_or;

endmodule

// File: tb/tb_p_beid_interconnect_f0_ahb_mtx_decoder.sv
// Bench for the AHB matrix decoder: directed protocol scenarios plus random traffic,
// checked through a scoreboard queue against a transfer-level reference model.
module tb_p_beid_interconnect_f0_ahb_mtx_decoder;
  localparam int NSLV   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  // slave0 0x0xxx_xxxx, slave1 0x1xxx_xxxx, slave2 0x2xxx_xxxx, slave3 bits[29:28]==01 (overlaps slave1)
  localparam logic [NSLV*ADDR_W-1:0] BASE_P = {32'h1000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NSLV*ADDR_W-1:0] MASK_P = {32'h3000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

  logic                   HCLK;
  logic                   HRESETn;
  logic                   HSEL;
  logic [ADDR_W-1:0]      HADDR;
  logic [1:0]             HTRANS;
  logic                   HREADY;
  logic [NSLV-1:0]        HSELS;
  logic                   HSELDEF;
  logic [NSLV-1:0]        HREADYOUTS;
  logic [2*NSLV-1:0]      HRESPS;
  logic [NSLV*DATA_W-1:0] HRDATAS;
  logic                   HREADYOUTDEF;
  logic [1:0]             HRESPDEF;
  logic                   HREADYOUT;
  logic [1:0]             HRESP;
  logic [DATA_W-1:0]      HRDATA;

  p_beid_interconnect_f0_ahb_mtx_decoder #(
    .NSLV(NSLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE(BASE_P), .MASK(MASK_P)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HREADY(HREADY), .HSELS(HSELS), .HSELDEF(HSELDEF), .HREADYOUTS(HREADYOUTS),
    .HRESPS(HRESPS), .HRDATAS(HRDATAS), .HREADYOUTDEF(HREADYOUTDEF), .HRESPDEF(HRESPDEF),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  typedef struct {
    logic [NSLV-1:0]   sels;
    logic              def;
    logic              rdy;
    logic [1:0]        resp;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int tests = 0;
  int fails = 0;
  int tgt = -1; // data-phase owner: -1 none, NSLV default slave, else slave index

  logic [ADDR_W-1:0] region_base [NSLV] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h1000_0000};
  logic [ADDR_W-1:0] region_mask [NSLV] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'h3000_0000};

  function automatic int region_of(input logic [ADDR_W-1:0] a);
    for (int i = 0; i < NSLV; i++) begin
      if ((a & region_mask[i]) == (region_base[i] & region_mask[i])) return i;
    end
    return NSLV;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NSLV*DATA_W-1:0] rnd_rd();
    logic [NSLV*DATA_W-1:0] v;
    for (int i = 0; i < NSLV; i++) v[i*DATA_W +: DATA_W] = $urandom();
    return v;
  endfunction

  // Expected port view for the current cycle; HREADY is fed back as the matrix would.
  task automatic apply();
    exp_t e;
    int   s;
    s      = HSEL ? region_of(HADDR) : -1;
    e.sels = '0;
    e.def  = (s == NSLV);
    if (s >= 0 && s < NSLV) e.sels[s] = 1'b1;
    if (tgt < 0) begin
      e.rdy = 1'b1; e.resp = 2'b00; e.data = '0;
    end else if (tgt == NSLV) begin
      e.rdy = HREADYOUTDEF; e.resp = HRESPDEF; e.data = '0;
    end else begin
      e.rdy  = HREADYOUTS[tgt];
      e.resp = HRESPS[2*tgt +: 2];
      e.data = HRDATAS[tgt*DATA_W +: DATA_W];
    end
    HREADY = e.rdy;
    q.push_back(e);
  endtask

  task automatic drv(input logic sel, input logic [ADDR_W-1:0] addr, input logic [NSLV-1:0] rdys,
                     input logic [2*NSLV-1:0] resps, input logic rdef, input logic [1:0] rsdef,
                     input logic [NSLV*DATA_W-1:0] rd);
    HSEL = sel; HADDR = addr; HTRANS = sel ? 2'b10 : 2'b00;
    HREADYOUTS = rdys; HRESPS = resps; HREADYOUTDEF = rdef; HRESPDEF = rsdef; HRDATAS = rd;
    apply();
    #1;
  endtask

  task automatic tick();
    @(posedge HCLK);
    if (HRESETn && HREADY) tgt = HSEL ? region_of(HADDR) : -1;
    #1;
  endtask

  always @(negedge HCLK) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      cmp("sb_hsels",   {60'd0, HSELS},     {60'd0, mon_e.sels});
      cmp("sb_hseldef", {63'd0, HSELDEF},   {63'd0, mon_e.def});
      cmp("sb_hready",  {63'd0, HREADYOUT}, {63'd0, mon_e.rdy});
      cmp("sb_hresp",   {62'd0, HRESP},     {62'd0, mon_e.resp});
      cmp("sb_hrdata",  {32'd0, HRDATA},    {32'd0, mon_e.data});
    end
  end

  initial begin
    logic [NSLV*DATA_W-1:0] rd;
    logic [2*NSLV-1:0]      rs;
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HREADY = 1'b1;
    HREADYOUTS = '1; HRESPS = '0; HRDATAS = '0; HREADYOUTDEF = 1'b1; HRESPDEF = 2'b00;
    @(posedge HCLK); #1;

    // held in reset: outputs stay at the "none" values whatever the slaves do
    for (int i = 0; i < 2; i++) begin
      drv(1'b1, 32'h2000_0000, 4'b0000, 8'h55, 1'b0, 2'b01, rnd_rd());
      cmp("rst_rdy", {63'd0, HREADYOUT}, 64'd1);
      cmp("rst_resp", {62'd0, HRESP}, 64'd0);
      cmp("rst_data", {32'd0, HRDATA}, 64'd0);
      tick();
    end

    HRESETn = 1'b1;
    drv(1'b1, 32'h2000_0010, 4'b1011, 8'h55, 1'b0, 2'b01, rnd_rd());
    cmp("rel_rdy", {63'd0, HREADYOUT}, 64'd1);
    cmp("rel_resp", {62'd0, HRESP}, 64'd0);
    cmp("rel_data", {32'd0, HRDATA}, 64'd0);
    cmp("dec_s2", {60'd0, HSELS}, 64'b0100);
    cmp("dec_s2_def", {63'd0, HSELDEF}, 64'd0);
    tick();

    rd = rnd_rd();
    drv(1'b1, 32'h1800_0000, 4'b1111, 8'h00, 1'b1, 2'b00, rd);
    cmp("ovl_sels", {60'd0, HSELS}, 64'b0010);
    cmp("s2_data", {32'd0, HRDATA}, {32'd0, rd[2*DATA_W +: DATA_W]});
    tick();

    drv(1'b1, 32'hF000_0000, 4'b1111, 8'h00, 1'b1, 2'b00, rnd_rd());
    cmp("unm_def", {63'd0, HSELDEF}, 64'd1);
    cmp("unm_sels", {60'd0, HSELS}, 64'd0);
    tick();

    // two-cycle ERROR from the default slave with slave0 waiting in address phase
    drv(1'b1, 32'h0000_0100, 4'b1111, 8'h00, 1'b0, 2'b01, rnd_rd());
    cmp("err1_rdy", {63'd0, HREADYOUT}, 64'd0);
    cmp("err1_resp", {62'd0, HRESP}, 64'd1);
    cmp("err1_data", {32'd0, HRDATA}, 64'd0);
    tick();
    drv(1'b1, 32'h0000_0100, 4'b1111, 8'h00, 1'b1, 2'b01, rnd_rd());
    cmp("err2_rdy", {63'd0, HREADYOUT}, 64'd1);
    cmp("err2_resp", {62'd0, HRESP}, 64'd1);
    cmp("err2_data", {32'd0, HRDATA}, 64'd0);
    tick();

    // slave0 read with two wait states, slave1 read pipelined behind it
    for (int i = 0; i < 2; i++) begin
      drv(1'b1, 32'h1000_0004, 4'b1110, 8'h00, 1'b1, 2'b00, rnd_rd());
      cmp("b2b_wait", {63'd0, HREADYOUT}, 64'd0);
      tick();
    end
    rd = rnd_rd();
    drv(1'b1, 32'h1000_0004, 4'b1111, 8'h00, 1'b1, 2'b00, rd);
    cmp("b2b_s0_data", {32'd0, HRDATA}, {32'd0, rd[0 +: DATA_W]});
    tick();
    rd = rnd_rd();
    drv(1'b0, 32'h0, 4'b1111, 8'h00, 1'b1, 2'b00, rd);
    cmp("b2b_s1_data", {32'd0, HRDATA}, {32'd0, rd[DATA_W +: DATA_W]});
    tick();

    // reset while slave2 stalls
    drv(1'b1, 32'h2000_0040, 4'b1111, 8'h00, 1'b1, 2'b00, rnd_rd());
    tick();
    drv(1'b0, 32'h0, 4'b1011, 8'h04, 1'b1, 2'b00, rnd_rd());
    cmp("mr_wait", {63'd0, HREADYOUT}, 64'd0);
    tick();
    HRESETn = 1'b0;
    tgt = -1;
    drv(1'b0, 32'h0, 4'b1011, 8'h10, 1'b1, 2'b00, rnd_rd());
    cmp("mr_rdy", {63'd0, HREADYOUT}, 64'd1);
    cmp("mr_resp", {62'd0, HRESP}, 64'd0);
    tick();
    HRESETn = 1'b1;

    for (int i = 0; i < 3; i++) begin
      drv(1'b0, $urandom(), 4'($urandom()), 8'h55, 1'b0, 2'b01, rnd_rd());
      cmp("idle_rdy", {63'd0, HREADYOUT}, 64'd1);
      cmp("idle_resp", {62'd0, HRESP}, 64'd0);
      cmp("idle_sels", {60'd0, HSELS}, 64'd0);
      cmp("idle_def", {63'd0, HSELDEF}, 64'd0);
      tick();
    end

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NSLV; i++) rs[2*i +: 2] = {1'b0, 1'($urandom_range(0, 1))};
      drv(1'($urandom_range(0, 3) != 0), {4'($urandom()), 28'($urandom())},
          4'($urandom() | $urandom()), rs, 1'($urandom_range(0, 2) != 0),
          {1'b0, 1'($urandom_range(0, 1))}, rnd_rd());
      tick();
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge HCLK);
    if (q.size() > 0) begin
      fails++;
      $display("FAIL sb_drain: %0d entries left, expected 0", q.size());
    end
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
